// File: rtl/cam_capture_pack.sv
// cam_capture_pack: OV7670 byte capture with crop, frame decimation
// and word packing toward the camera-to-SDRAM FIFO write port.
module cam_capture_pack #(
  parameter int WORD_BYTES = 2,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int DEC_W      = 4
) (
  input  logic                    PCLK_cam,
  input  logic                    rst_n,
  input  logic [7:0]              data_cam,
  input  logic                    VSYNC_cam,
  input  logic                    HREF_cam,
  input  logic                    cfg_en,
  input  logic [X_W-1:0]          cfg_x0,
  input  logic [X_W-1:0]          cfg_x1,
  input  logic [Y_W-1:0]          cfg_y0,
  input  logic [Y_W-1:0]          cfg_y1,
  input  logic [DEC_W-1:0]        cfg_decim,
  input  logic                    wr_full,
  output logic                    wr_req,
  output logic [8*WORD_BYTES-1:0] wr_data,
  output logic                    wr_sof,
  output logic                    wr_eol,
  output logic                    ovf,
  input  logic                    ovf_clr,
  output logic                    align_err,
  output logic [15:0]             frame_cnt,
  output logic                    busy
);

  localparam int DW = 8 * WORD_BYTES;
  localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ACTIVE,
    SKIP
  } state_t;

  state_t state, state_nxt;

  logic             vs_q, vs_qq;
  logic             hr_q, hr_qq;
  logic [7:0]       d_q;
  logic             vs_rise, vs_fall;
  logic             hr_rise, hr_fall;

  logic [X_W-1:0]   x_cnt, cur_x;
  logic [Y_W-1:0]   y_cnt;
  logic [DEC_W-1:0] dec_cnt;

  logic [X_W-1:0]   x0_r, x1_r;
  logic [Y_W-1:0]   y0_r, y1_r;
  logic [DEC_W-1:0] dec_r;

  logic [DW-1:0]    pk_sh, word;
  logic [CW-1:0]    pk_cnt;
  logic             sof_done;
  logic             drop;

  logic             sync_entry;
  logic             sync_exit;
  logic             keep, done;
  logic             ovf_set, aln_set;

  always_ff @(posedge PCLK_cam or negedge rst_n) begin
    if (!rst_n) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      hr_q  <= 1'b0;
      hr_qq <= 1'b0;
      d_q   <= '0;
    end else begin
      vs_q  <= VSYNC_cam;
      vs_qq <= vs_q;
      hr_q  <= HREF_cam;
      hr_qq <= hr_q;
      d_q   <= data_cam;
    end
  end

  assign vs_rise = vs_q & ~vs_qq;
  assign vs_fall = ~vs_q & vs_qq;
  assign hr_rise = hr_q & ~hr_qq;
  assign hr_fall = ~hr_q & hr_qq;

  always_comb begin
    state_nxt  = state;
    sync_entry = 1'b0;
    sync_exit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (vs_rise && cfg_en) begin
          state_nxt  = SYNC;
          sync_entry = 1'b1;
        end
      end
      SYNC: begin
        if (vs_fall) begin
          sync_exit = 1'b1;
          state_nxt = (dec_cnt == '0) ? ACTIVE : SKIP;
        end
      end
      ACTIVE, SKIP: begin
        if (vs_rise) begin
          state_nxt  = cfg_en ? SYNC : IDLE;
          sync_entry = cfg_en;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK_cam or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign cur_x = hr_rise ? '0 : x_cnt;
  assign word  = (pk_sh << 8) | DW'(d_q);

  always_comb begin
    keep = (state == ACTIVE) && hr_q
        && (cur_x >= x0_r) && (cur_x <= x1_r)
        && (y_cnt >= y0_r) && (y_cnt <= y1_r);
    done    = keep && (pk_cnt == LAST);
    ovf_set = done && !drop && wr_full;
    aln_set = hr_fall && (pk_cnt != '0);
  end

  always_ff @(posedge PCLK_cam or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      dec_cnt <= '0;
    end else begin
      if (hr_q) x_cnt <= cur_x + 1'b1;
      if (vs_fall)      y_cnt <= '0;
      else if (hr_fall) y_cnt <= y_cnt + 1'b1;
      // A fresh capture session always takes its first frame.
      if (sync_entry && state == IDLE) begin
        dec_cnt <= '0;
      end else if (sync_exit) begin
        if (dec_cnt >= dec_r) dec_cnt <= '0;
        else                  dec_cnt <= dec_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK_cam or negedge rst_n) begin
    if (!rst_n) begin
      x0_r  <= '0;
      x1_r  <= '0;
      y0_r  <= '0;
      y1_r  <= '0;
      dec_r <= '0;
    end else if (sync_entry) begin
      x0_r  <= cfg_x0;
      x1_r  <= cfg_x1;
      y0_r  <= cfg_y0;
      y1_r  <= cfg_y1;
      dec_r <= cfg_decim;
    end
  end

  always_ff @(posedge PCLK_cam or negedge rst_n) begin
    if (!rst_n) begin
      pk_sh    <= '0;
      pk_cnt   <= '0;
      sof_done <= 1'b0;
      drop     <= 1'b0;
      wr_req   <= 1'b0;
      wr_data  <= '0;
      wr_sof   <= 1'b0;
      wr_eol   <= 1'b0;
    end else begin
      wr_req <= 1'b0;
      wr_sof <= 1'b0;
      wr_eol <= 1'b0;
      if (sync_entry) begin
        pk_cnt   <= '0;
        sof_done <= 1'b0;
        drop     <= 1'b0;
      end else if (aln_set) begin
        pk_cnt <= '0;
      end else if (done) begin
        pk_cnt <= '0;
        // After a drop the frame stays silent until the next SYNC.
        if (wr_full) begin
          drop <= 1'b1;
        end else if (!drop) begin
          wr_req   <= 1'b1;
          wr_data  <= word;
          wr_sof   <= !sof_done;
          wr_eol   <= (cur_x == x1_r);
          sof_done <= 1'b1;
        end
      end else if (keep) begin
        pk_sh  <= word;
        pk_cnt <= pk_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK_cam or negedge rst_n) begin
    if (!rst_n) begin
      ovf       <= 1'b0;
      align_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      ovf       <= ovf_set | (ovf & ~ovf_clr);
      align_err <= (aln_set && !sync_entry)
                 | (align_err & ~ovf_clr);
      if (state == ACTIVE && vs_rise && !drop)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cam_capture_pack.sv
// Directed bench for cam_capture_pack: 16-bit and 32-bit packers
// driven from one camera stream.
module tb_cam_capture_pack;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data;
  logic        VSYNC, HREF;
  logic        cfg_en;
  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
  logic [3:0]  decim;
  logic        wr_full;
  logic        ovf_clr;

  logic        wr_req, wr_sof, wr_eol, ovf, align_err, busy;
  logic [15:0] wr_data, frame_cnt;
  logic        wr_req4, wr_sof4, wr_eol4, ovf4, align_err4, busy4;
  logic [31:0] wr_data4;
  logic [15:0] frame_cnt4;

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  int fbase = 0;
  int mark_cyc = 0;
  int busy_low = 0;
  bit busy_arm = 0;
  logic pre_req, snap_req, pre_busy, snap_busy;
  logic [15:0] snap_fc;

  logic [15:0] q_data[$];
  bit          q_sof[$];
  bit          q_eol[$];
  int          q_cyc[$];
  logic [31:0] q4_data[$];
  bit          q4_eol[$];

  cam_capture_pack #(.WORD_BYTES(2)) dut (
    .PCLK_cam(clk), .rst_n(rst_n), .data_cam(data),
    .VSYNC_cam(VSYNC), .HREF_cam(HREF), .cfg_en(cfg_en),
    .cfg_x0(x0), .cfg_x1(x1), .cfg_y0(y0), .cfg_y1(y1),
    .cfg_decim(decim), .wr_full(wr_full), .wr_req(wr_req),
    .wr_data(wr_data), .wr_sof(wr_sof), .wr_eol(wr_eol),
    .ovf(ovf), .ovf_clr(ovf_clr), .align_err(align_err),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  cam_capture_pack #(.WORD_BYTES(4)) dut4 (
    .PCLK_cam(clk), .rst_n(rst_n), .data_cam(data),
    .VSYNC_cam(VSYNC), .HREF_cam(HREF), .cfg_en(cfg_en),
    .cfg_x0(x0), .cfg_x1(x1), .cfg_y0(y0), .cfg_y1(y1),
    .cfg_decim(decim), .wr_full(wr_full), .wr_req(wr_req4),
    .wr_data(wr_data4), .wr_sof(wr_sof4), .wr_eol(wr_eol4),
    .ovf(ovf4), .ovf_clr(ovf_clr), .align_err(align_err4),
    .frame_cnt(frame_cnt4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_req) begin
      q_data.push_back(wr_data);
      q_sof.push_back(wr_sof);
      q_eol.push_back(wr_eol);
      q_cyc.push_back(cyc);
    end
    if (wr_req4) begin
      q4_data.push_back(wr_data4);
      q4_eol.push_back(wr_eol4);
    end
    if (busy_arm && !busy) busy_low++;
  end

  task automatic clear_q();
    q_data.delete();
    q_sof.delete();
    q_eol.delete();
    q_cyc.delete();
    q4_data.delete();
    q4_eol.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_q();
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    VSYNC = 1'b1;
    repeat (3) @(negedge clk);
    VSYNC = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_frame(input int nl, input int nb,
                            input bit full_en, input bit rst_mid,
                            input bit en_drop);
    vs_pulse();
    for (int l = 0; l < nl; l++) begin
      for (int x = 0; x < nb; x++) begin
        @(negedge clk);
        HREF = 1'b1;
        data = 8'(fbase + x);
        wr_full = full_en && (l == 0) && (x == 5 || x == 6);
        if (l == 0 && x == 1) mark_cyc = cyc;
        if (en_drop && l == 0 && x == 3) cfg_en = 1'b0;
        if (rst_mid && l == 0 && x == 3) begin
          pre_req  = wr_req;
          pre_busy = busy;
          #1 rst_n = 1'b0;
          #1;
          snap_req  = wr_req;
          snap_busy = busy;
          snap_fc   = frame_cnt;
          clear_q();
          #1 rst_n = 1'b1;
        end
      end
      @(negedge clk);
      HREF = 1'b0;
      data = 8'h00;
      wr_full = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic set_win(input int a, input int b,
                         input int c, input int d);
    x0 = 11'(a);
    x1 = 11'(b);
    y0 = 10'(c);
    y1 = 10'(d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    vec++;
    if ({wr_req, wr_sof, wr_eol, ovf, align_err, busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {wr_req, wr_sof, wr_eol, ovf, align_err, busy});
    end
    vec++;
    if (wr_data !== 16'h0 || frame_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h want=0000/0000",
               wr_data, frame_cnt);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] exp[4] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607};
    do_reset();
    set_win(0, 7, 0, 1);
    decim = 0;
    fbase = 0;
    send_frame(2, 8, 0, 0, 0);
    vs_pulse();
    vec++;
    if (q_data.size() != 8) begin
      bad++;
      $display("FAIL basic_count got=%0d want=8", q_data.size());
    end
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      vec++;
      if (q_data[i] !== exp[i%4] || q_sof[i] !== (i == 0)
          || q_eol[i] !== (i == 3 || i == 7)) begin
        bad++;
        $display("FAIL basic_word%0d got=%h sof=%b eol=%b want=%h sof=%b eol=%b",
                 i, q_data[i], q_sof[i], q_eol[i], exp[i%4],
                 (i == 0), (i == 3 || i == 7));
      end
    end
    vec++;
    if (q_cyc.size() < 1 || q_cyc[0] - mark_cyc != 2) begin
      bad++;
      $display("FAIL basic_latency got=%0d want=2",
               (q_cyc.size() < 1) ? -1 : q_cyc[0] - mark_cyc);
    end
    vec++;
    if (frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL basic_frame_cnt got=%0d want=1", frame_cnt);
    end
    vec++;
    if (q4_data.size() != 4 || q4_data[0] !== 32'h00010203
        || q4_data[1] !== 32'h04050607 || q4_eol[1] !== 1'b1
        || align_err4 !== 1'b0) begin
      bad++;
      $display("FAIL basic_w4 got n=%0d w0=%h align=%b want n=4 w0=00010203 align=0",
               q4_data.size(),
               (q4_data.size() > 0) ? q4_data[0] : 32'hx, align_err4);
    end
  endtask

  task automatic test_crop();
    do_reset();
    set_win(2, 5, 1, 2);
    decim = 0;
    fbase = 0;
    send_frame(4, 8, 0, 0, 0);
    vec++;
    if (q_data.size() != 4) begin
      bad++;
      $display("FAIL crop_count got=%0d want=4", q_data.size());
    end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      vec++;
      if (q_data[i] !== ((i % 2 == 0) ? 16'h0203 : 16'h0405)
          || q_sof[i] !== (i == 0) || q_eol[i] !== (i % 2 == 1)) begin
        bad++;
        $display("FAIL crop_word%0d got=%h sof=%b eol=%b want=%h sof=%b eol=%b",
                 i, q_data[i], q_sof[i], q_eol[i],
                 (i % 2 == 0) ? 16'h0203 : 16'h0405,
                 (i == 0), (i % 2 == 1));
      end
    end
  endtask

  task automatic test_decim();
    logic [15:0] exp[6] = '{16'h0001, 16'h0203, 16'h3031,
                            16'h3233, 16'h6061, 16'h6263};
    do_reset();
    set_win(0, 3, 0, 0);
    decim = 4'd2;
    busy_low = 0;
    for (int f = 0; f < 7; f++) begin
      fbase = 16 * f;
      send_frame(1, 4, 0, 0, 0);
      busy_arm = 1'b1;
    end
    vs_pulse();
    busy_arm = 1'b0;
    vec++;
    if (q_data.size() != 6) begin
      bad++;
      $display("FAIL decim_count got=%0d want=6", q_data.size());
    end
    for (int i = 0; i < 6 && i < q_data.size(); i++) begin
      vec++;
      if (q_data[i] !== exp[i] || q_sof[i] !== (i % 2 == 0)) begin
        bad++;
        $display("FAIL decim_word%0d got=%h sof=%b want=%h sof=%b",
                 i, q_data[i], q_sof[i], exp[i], (i % 2 == 0));
      end
    end
    vec++;
    if (frame_cnt !== 16'd3 || busy_low != 0) begin
      bad++;
      $display("FAIL decim_status got fc=%0d busy_low=%0d want fc=3 busy_low=0",
               frame_cnt, busy_low);
    end
    decim = 4'd0;
  endtask

  task automatic test_overflow();
    do_reset();
    set_win(0, 7, 0, 1);
    fbase = 0;
    send_frame(2, 8, 1, 0, 0);
    vec++;
    if (q_data.size() != 2 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_drop got n=%0d ovf=%b want n=2 ovf=1",
               q_data.size(), ovf);
    end
    send_frame(2, 8, 0, 0, 0);
    vs_pulse();
    vec++;
    if (q_data.size() != 10 || q_data[2] !== 16'h0001
        || q_sof[2] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_next got n=%0d want n=10 with sof word 0001",
               q_data.size());
    end
    vec++;
    if (frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL ovf_frame_cnt got=%0d want=1", frame_cnt);
    end
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    vec++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr got=%b want=0", ovf);
    end
  endtask

  task automatic test_word4();
    do_reset();
    set_win(0, 5, 0, 1);
    fbase = 0;
    send_frame(2, 8, 0, 0, 0);
    vec++;
    if (q4_data.size() != 2 || q4_data[0] !== 32'h00010203
        || q4_data[1] !== 32'h00010203) begin
      bad++;
      $display("FAIL w4_words got n=%0d want n=2 of 00010203",
               q4_data.size());
    end
    vec++;
    if (q4_eol.size() != 2 || q4_eol[0] || q4_eol[1]
        || align_err4 !== 1'b1) begin
      bad++;
      $display("FAIL w4_flags got align=%b want eol=0 align=1",
               align_err4);
    end
    vec++;
    if (q_data.size() != 6 || q_eol[2] !== 1'b1
        || q_data[2] !== 16'h0405 || align_err !== 1'b0) begin
      bad++;
      $display("FAIL w2_x1_5 got n=%0d align=%b want n=6 eol word 0405 align=0",
               q_data.size(), align_err);
    end
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    vec++;
    if (align_err4 !== 1'b0) begin
      bad++;
      $display("FAIL w4_align_clr got=%b want=0", align_err4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_win(0, 7, 0, 1);
    fbase = 0;
    send_frame(2, 8, 0, 0, 0);
    send_frame(2, 8, 0, 1, 0);
    vec++;
    if (pre_req !== 1'b1 || pre_busy !== 1'b1 || snap_req !== 1'b0
        || snap_busy !== 1'b0 || snap_fc !== 16'd0) begin
      bad++;
      $display("FAIL rst_async got pre=%b%b post=%b%b fc=%0d want 11 00 0",
               pre_req, pre_busy, snap_req, snap_busy, snap_fc);
    end
    vec++;
    if (q_data.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_quiet got n=%0d busy=%b want n=0 busy=0",
               q_data.size(), busy);
    end
    send_frame(2, 8, 0, 0, 1);
    vec++;
    if (q_data.size() != 8 || busy !== 1'b1) begin
      bad++;
      $display("FAIL en_drop_frame got n=%0d busy=%b want n=8 busy=1",
               q_data.size(), busy);
    end
    vs_pulse();
    vec++;
    if (busy !== 1'b0 || frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL en_drop_idle got busy=%b fc=%0d want busy=0 fc=1",
               busy, frame_cnt);
    end
    cfg_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    data = 8'h00;
    VSYNC = 1'b0;
    HREF = 1'b0;
    cfg_en = 1'b1;
    set_win(0, 7, 0, 1);
    decim = 4'd0;
    wr_full = 1'b0;
    ovf_clr = 1'b0;
    test_reset();
    test_basic();
    test_crop();
    test_decim();
    test_overflow();
    test_word4();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/cam_capture_pack.md
Name: cam_capture_pack

Overview:
- Parametrised successor to the camera input wrapper, sitting between the OV7670 pins and the PCLK-side write port of the camera-to-SDRAM FIFO.
- Single PCLK_cam domain.
- Packs camera bytes into WORD_BYTES-wide words and crops each frame to a programmable byte/line window.
- Adds frame decimation, start-of-frame and end-of-line tags, FIFO-full handling at frame granularity, and status counters.

Parameters:
- WORD_BYTES, 2: bytes packed per output word (legal values 1, 2, 4); wr_data width is 8*WORD_BYTES.
- X_W, 11: width of the byte-column counter and of cfg_x0/cfg_x1.
- Y_W, 10: width of the line counter and of cfg_y0/cfg_y1.
- DEC_W, 4: width of cfg_decim.

Ports:
- PCLK_cam  in  1  camera pixel clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- data_cam  in  8  camera data byte.
- VSYNC_cam  in  1  frame sync, active high.
- HREF_cam  in  1  line valid, active high.
- cfg_en  in  1  capture enable; sampled only at frame boundaries.
- cfg_x0, cfg_x1  in  X_W  first and last byte column kept, inclusive.
- cfg_y0, cfg_y1  in  Y_W  first and last line kept, inclusive.
- cfg_decim  in  DEC_W  capture 1 frame out of every cfg_decim+1.
- wr_full  in  1  downstream FIFO full.
- wr_req  out  1  one-cycle write strobe.
- wr_data  out  8*WORD_BYTES  packed word; first byte in the MSBs.
- wr_sof  out  1  qualifies wr_req: first word of a frame.
- wr_eol  out  1  qualifies wr_req: last word of a line.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.
- align_err  out  1  sticky; a line ended with a partial word. Cleared by ovf_clr.
- frame_cnt  out  16  count of frames delivered completely; wraps.
- busy  out  1  high while not in IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Input registering: VSYNC_cam, HREF_cam and data_cam are registered once. Edges are detected on the registered copies.
- Counters:
  - x (byte column) clears on the HREF rising edge and increments per byte while HREF is high.
  - y (line) clears on the VSYNC falling edge and increments on each HREF falling edge.
- States:
  - IDLE -> SYNC on VSYNC rising edge with cfg_en=1. The decimation counter clears on this transition, so the first frame is always captured.
  - SYNC -> ACTIVE on VSYNC falling edge if the decimation counter is 0, else SYNC -> SKIP.
  - The decimation counter increments on each SYNC exit and wraps at cfg_decim.
  - ACTIVE or SKIP -> SYNC on VSYNC rising edge if cfg_en=1, else -> IDLE.
  - Deasserting cfg_en mid-frame lets the current frame finish.
- Cfg sampling: all cfg_* inputs are sampled on SYNC entry and held for the whole frame.
- Packing (ACTIVE only):
  - A byte is kept when x0<=x<=x1 and y0<=y<=y1; it is shifted into the packer.
  - When the WORD_BYTES-th kept byte is sampled, the word is complete.
  - Latency: the last byte is on data_cam at edge n; wr_req is high in the cycle after edge n+1, for exactly one cycle.
  - wr_data is valid only while wr_req is high.
  - wr_sof is set on the first word written in the frame.
  - wr_eol is set when the word's last byte has x==x1.
- Partial words: at an HREF falling edge with a partial word pending, the bytes are discarded, the packer clears and align_err is set. This applies when (x1-x0+1) is not a multiple of WORD_BYTES.
- Overflow:
  - If a word completes while wr_full=1, the word is dropped and ovf is set.
  - No further wr_req is issued until the next frame, and that frame does not increment frame_cnt.
  - If set and clear occur in the same cycle, set wins.
- frame_cnt: increments on the VSYNC rising edge that ends an ACTIVE frame that had no drop.
- Window edge cases:
  - x0>x1 or y0>y1: no words are written, but the frame still counts.
  - The window exceeding the real frame size simply truncates.
- Async reset mid-frame: every register returns to its reset value immediately; capture restarts at the next VSYNC rising edge.

Test Plan:
1. WORD_BYTES=2, x0=0, x1=7, y0=0, y1=1, decim=0, bytes 0x00,0x01,... per line -> 8 wr_req; words 0x0001, 0x0203, 0x0405, 0x0607 per line; wr_sof on word 1 only; wr_eol on words 4 and 8; frame_cnt=1.
2. Crop x0=2, x1=5, y0=1, y1=2 on a 4-line frame of 8 bytes/line -> 4 words total; first word 0x0203 from line 1; eol on words 2 and 4.
3. cfg_decim=2, 7 frames -> frames 1, 4, 7 captured; busy=1 throughout; frame_cnt=3.
4. wr_full=1 when word 3 completes -> word dropped; ovf=1; no further wr_req in that frame; next frame fully written; frame_cnt=1 after two frames; ovf_clr -> ovf=0.
5. WORD_BYTES=4, x0=0, x1=5 -> 1 word per line (0x00010203); align_err=1; wr_eol never asserted.
6. rst_n low mid-line, then high -> outputs 0 at once; no wr_req until after the next VSYNC rising edge; cfg_en=0 mid-frame -> frame completes, then IDLE, busy=0.
